// File: rtl/memory_march_tester.sv
// memory_march_tester: March C- built-in self-test initiator.
// Drives the write/read ports of a simple synchronous memory, checks every
// returned read word against the background pattern, and reports pass/fail,
// a saturating mismatch count and the first failing location.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start; results from the last test are held
//   ST_RUN   | issuing March elements E0..E5, one memory operation per cycle
//   ST_DRAIN | no new operations; waiting for the last RD_LATENCY compares
//   ST_DONE  | one-cycle completion, done pulse and final pass verdict
module memory_march_tester #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [DATA_WIDTH-1:0] err_expected,
    output logic [DATA_WIDTH-1:0] err_actual,
    output logic [15:0]           err_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    // March elements; E0 is write-only, E5 read-only, E1..E4 are (read, write) pairs.
    typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] P0        = PATTERN;
    localparam logic [DATA_WIDTH-1:0] P1        = ~PATTERN;
    localparam int                    DRAIN_W   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [DRAIN_W-1:0]    DRAIN_LD  = DRAIN_W'(RD_LATENCY - 1);

    state_t                state_q, state_d;
    elem_t                 elem_q, elem_d;
    logic                  phase_q, phase_d;        // 0: read half, 1: write half
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] rd_exp_q, rd_exp_d;      // expected word for the read on the port
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [DATA_WIDTH-1:0] err_expected_q, err_expected_d;
    logic [DATA_WIDTH-1:0] err_actual_q, err_actual_d;
    logic [15:0]           err_count_q, err_count_d;

    // Compare pipeline: stage k holds the read issued k+1 cycles ago.
    logic                  pipe_vld_q  [RD_LATENCY];
    logic                  pipe_vld_d  [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] pipe_addr_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] pipe_addr_d [RD_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_exp_q  [RD_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_exp_d  [RD_LATENCY];

    logic                  accept_start;
    logic                  run_next;
    logic                  write_next;
    logic                  read_next;
    logic                  cmp_vld;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic [DATA_WIDTH-1:0] cmp_exp;
    logic                  mismatch;

    assign accept_start = (state_q == ST_IDLE) && start;

    // Sequencer: next FSM state and the March position of the next cycle's operation.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    elem_d  = E0;
                    phase_d = 1'b1;
                    addr_d  = '0;
                end
            end
            ST_RUN: begin
                case (elem_q)
                    E0: begin
                        if (addr_q == LAST_ADDR) begin
                            elem_d  = E1;
                            phase_d = 1'b0;
                            addr_d  = '0;
                        end else begin
                            addr_d = addr_q + ADDR_ONE;
                        end
                    end
                    E1, E2: begin
                        if (!phase_q) begin
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (addr_q == LAST_ADDR) begin
                                // E1 hands over to ascending E2, E2 to descending E3.
                                elem_d = (elem_q == E1) ? E2 : E3;
                                addr_d = (elem_q == E1) ? '0 : LAST_ADDR;
                            end else begin
                                addr_d = addr_q + ADDR_ONE;
                            end
                        end
                    end
                    E3, E4: begin
                        if (!phase_q) begin
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (addr_q == '0) begin
                                elem_d = (elem_q == E3) ? E4 : E5;
                                addr_d = (elem_q == E3) ? LAST_ADDR : '0;
                            end else begin
                                addr_d = addr_q - ADDR_ONE;
                            end
                        end
                    end
                    E5: begin
                        if (addr_q == LAST_ADDR) begin
                            state_d     = ST_DRAIN;
                            drain_cnt_d = DRAIN_LD;
                        end else begin
                            addr_d = addr_q + ADDR_ONE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-port outputs for the next cycle, decoded from the next March position.
    always_comb begin
        run_next   = (state_d == ST_RUN);
        write_next = run_next && ((elem_d == E0) || ((elem_d != E5) && phase_d));
        read_next  = run_next && (elem_d != E0) && !phase_d;
        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
        wr_en_d    = write_next;
        rd_en_d    = read_next;
        wr_addr_d  = write_next ? addr_d : wr_addr_q;
        wr_data_d  = wr_data_q;
        if (write_next) begin
            wr_data_d = ((elem_d == E1) || (elem_d == E3)) ? P1 : P0;
        end
        rd_addr_d = read_next ? addr_d : rd_addr_q;
        rd_exp_d  = rd_exp_q;
        if (read_next) begin
            rd_exp_d = ((elem_d == E2) || (elem_d == E4)) ? P1 : P0;
        end
    end

    // Shift each issued read down the compare pipeline.
    always_comb begin
        pipe_vld_d[0]  = rd_en_q;
        pipe_addr_d[0] = rd_addr_q;
        pipe_exp_d[0]  = rd_exp_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
            pipe_exp_d[i]  = pipe_exp_q[i-1];
        end
    end

    assign cmp_vld  = pipe_vld_q[RD_LATENCY-1];
    assign cmp_addr = pipe_addr_q[RD_LATENCY-1];
    assign cmp_exp  = pipe_exp_q[RD_LATENCY-1];
    assign mismatch = cmp_vld && (rd_data != cmp_exp);

    // Result bookkeeping: clear on an accepted start, accumulate on mismatches.
    always_comb begin
        pass_d         = pass_q;
        fail_d         = fail_q;
        err_addr_d     = err_addr_q;
        err_expected_d = err_expected_q;
        err_actual_d   = err_actual_q;
        err_count_d    = err_count_q;
        if (accept_start) begin
            pass_d         = 1'b0;
            fail_d         = 1'b0;
            err_addr_d     = '0;
            err_expected_d = '0;
            err_actual_d   = '0;
            err_count_d    = '0;
        end else begin
            if (mismatch) begin
                fail_d = 1'b1;
                if (err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end
                if (!fail_q) begin
                    err_addr_d     = cmp_addr;
                    err_expected_d = cmp_exp;
                    err_actual_d   = rd_data;
                end
            end
            // The final compare can land in the last drain cycle, so fold it in here.
            if (state_d == ST_DONE) begin
                pass_d = !(fail_q || mismatch);
            end
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            elem_q      <= E0;
            phase_q     <= 1'b0;
            addr_q      <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Registered memory-port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            rd_exp_q       <= '0;
            err_addr_q     <= '0;
            err_expected_q <= '0;
            err_actual_q   <= '0;
            err_count_q    <= '0;
        end else begin
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            fail_q         <= fail_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            rd_en_q        <= rd_en_d;
            rd_addr_q      <= rd_addr_d;
            rd_exp_q       <= rd_exp_d;
            err_addr_q     <= err_addr_d;
            err_expected_q <= err_expected_d;
            err_actual_q   <= err_actual_d;
            err_count_q    <= err_count_d;
        end
    end

    // Compare pipeline registers; reset throws away reads still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_addr_q[i] <= '0;
                pipe_exp_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_d[i];
                pipe_addr_q[i] <= pipe_addr_d[i];
                pipe_exp_q[i]  <= pipe_exp_d[i];
            end
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign err_addr     = err_addr_q;
    assign err_expected = err_expected_q;
    assign err_actual   = err_actual_q;
    assign err_count    = err_count_q;

endmodule

// File: doc/memory_march_tester.md
# memory_march_tester

Built-in self-test initiator for the simple synchronous memory interface: separate write port (`wr_en`/`wr_addr`/`wr_data`) and read port (`rd_en`/`rd_addr`/`rd_data`). On `start`, it drives a March C- sequence into the memory and compares every returned read word against the expected background pattern. It reports pass/fail, an error count and the first failing location. It sits in front of any memory instance that the shadow-memory checker also observes, and provides the stimulus side of that interface.

## Interface
- `ADDR_WIDTH`, 8: address width.
- `DATA_WIDTH`, 32: data width.
- `DEPTH`, 256: number of locations tested (0..DEPTH-1); need not be a power of two; DEPTH ≤ 2^ADDR_WIDTH.
- `RD_LATENCY`, 1: cycles from `rd_en` sample to valid `rd_data`; ≥1.
- `PATTERN`, all-zeros: background word P0. P1 = ~PATTERN.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin test; sampled only when idle.
- `busy`  out  1  test in progress.
- `done`  out  1  one-cycle completion pulse.
- `pass`  out  1  test finished with zero mismatches; held.
- `fail`  out  1  sticky; ≥1 mismatch in current/last test.
- `wr_en`  out  1  memory write strobe.
- `wr_addr`  out  ADDR_WIDTH  write address.
- `wr_data`  out  DATA_WIDTH  write data.
- `rd_en`  out  1  memory read strobe.
- `rd_addr`  out  ADDR_WIDTH  read address.
- `rd_data`  in  DATA_WIDTH  read data, valid RD_LATENCY cycles after `rd_en`.
- `err_addr`  out  ADDR_WIDTH  address of first mismatch.
- `err_expected`  out  DATA_WIDTH  expected word at first mismatch.
- `err_actual`  out  DATA_WIDTH  returned word at first mismatch.
- `err_count`  out  16  mismatch count, saturates at 16'hFFFF.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN when `start`=1. On entry, clear `pass`, `fail`, `err_*`, `err_count`. `start` is ignored outside IDLE.
- RUN executes these elements in order. ⇑ means address 0→DEPTH-1; ⇓ means DEPTH-1→0.
  - E0: ⇑(w P0)
  - E1: ⇑(r P0, w P1)
  - E2: ⇑(r P1, w P0)
  - E3: ⇓(r P0, w P1)
  - E4: ⇓(r P1, w P0)
  - E5: ⇑(r P0)
- One operation per cycle. An (r,w) element spends 2 cycles per address: read cycle, then write to the same address in the next cycle.
- `wr_en` and `rd_en` are never high in the same cycle. No bubbles occur between elements, and the address never exceeds DEPTH-1.
- Each read pushes (address, expected word) into an RD_LATENCY-deep valid pipeline. When an entry emerges, compare it against `rd_data`. On mismatch:
  - increment `err_count` (saturating);
  - set `fail`;
  - capture `err_addr`, `err_expected` and `err_actual` only if this is the first mismatch of the test.
- After the last E5 read, go to DRAIN for RD_LATENCY cycles to finish outstanding compares. Then go to DONE for one cycle: `done`=1, and `pass`=!`fail`. Then return to IDLE.
- `pass`, `fail`, `err_*` and `err_count` hold until the next accepted `start` or `rst`.
- `rst` at any time, including mid-test, discards in-flight compares and returns to IDLE.

## Timing
- All outputs are registered. Reset values:
  - `busy`, `done`, `pass`, `fail`, `wr_en`, `rd_en` = 0;
  - `wr_addr`, `rd_addr`, `wr_data`, `err_addr`, `err_expected`, `err_actual` = 0;
  - `err_count` = 0.
- `wr_addr`/`rd_addr`/`wr_data` are meaningful only while their strobe is high.
- `start` is sampled at edge 0. Cycle n is the cycle after edge n-1.
- Operations occupy cycles 1..10·DEPTH: E0 takes DEPTH cycles, E1–E4 take 2·DEPTH each, E5 takes DEPTH.
- `busy`=1 in cycles 1..10·DEPTH+RD_LATENCY.
- `done`=1 only in cycle 10·DEPTH+RD_LATENCY+1. `pass`/`fail` are final from that cycle.
- `fail`, `err_count` and `err_*` update in the cycle after the compare cycle.
- The (r,w) ordering means the write never precedes its paired read. The first read of the next element may target the address written one cycle earlier, so the memory must support write-then-read on consecutive cycles.

## Test plan
- Ideal memory model, DEPTH=16, RD_LATENCY=1, PATTERN=0; pulse `start` → `done` at cycle 162, `pass`=1, `fail`=0, `err_count`=0, and no cycle has both strobes high.
- Same setup with bit 0 of address 5 stuck at 1 → `fail`=1, `pass`=0, `err_count`=3 (from E1, E3, E5), `err_addr`=5, `err_expected`=0x00000000, `err_actual`=0x00000001.
- Aliasing fault (a write to address 3 also writes address 7), DEPTH=16 → `err_addr`=7, `err_expected`=0x00000000, `err_actual`=0xFFFFFFFF, `fail`=1.
- `rst` in cycle 50 of a run → next cycle `busy`=`wr_en`=`rd_en`=0 and `err_count`=0. A new `start` with the ideal model → `done` 162 cycles later, `pass`=1. A second `start` pulse at cycle 20 of that run is ignored, giving exactly one `done`.
- DEPTH=5, RD_LATENCY=3, PATTERN=32'hA5A5A5A5, ideal model → addresses stay within 0..4, E3 starts at address 4, reads in E2/E4 expect 32'h5A5A5A5A, `done` at cycle 54, `pass`=1.
